uart_receiver: RTL
==================

Name: uart_receiver

Overview:
UART receive stage sitting directly downstream of the UART clock generator. It consumes the generator's 16x-oversample enable (rx_clk_en) and the asynchronous serial line. It recovers 8N1-style frames (start bit, DATA_BITS data bits LSB first, one stop bit). Each accepted byte is presented to the core with a one-cycle valid pulse; a bad stop bit raises a framing-error pulse instead.

Parameters:
DATA_BITS, 8, data bits per frame; legal range 5..8.
OVERSAMPLE, 16, rx_clk_en ticks per bit; fixed to match the clock generator's 16x rate.

Ports:
sys_clk  input  1  system clock; all logic is on the rising edge.
rst  input  1  synchronous, active-high reset.
rx_clk_en  input  1  single-cycle 16x-oversample tick from the clock generator.
rxd  input  1  asynchronous serial line; idles high.
rx_data  output  DATA_BITS  last correctly framed byte; holds its value until the next good frame.
rx_valid  output  1  one sys_clk pulse when rx_data is updated.
frame_err  output  1  one sys_clk pulse when a stop bit is sampled low.
rx_busy  output  1  high whenever state != IDLE.

Behaviour:
- Synchronizer: rxd passes through two flops every sys_clk, independent of rx_clk_en. Both flops reset to 1. rx_s is the second flop; the FSM uses only rx_s.
- FSM state, tick_cnt[3:0], bit_cnt and the shift register change only on cycles with rx_clk_en=1. Exceptions are reset and the pulse clearing described below.
- Reset values: state=IDLE, tick_cnt=0, bit_cnt=0, shift=0, rx_data=0, rx_valid=0, frame_err=0, rx_busy=0.
- IDLE: on a tick with rx_s=0, go to START with tick_cnt=0.
- START: each tick increments tick_cnt.
  - On the tick where tick_cnt==7 (mid start bit), sample rx_s.
  - If rx_s=0: go to DATA with tick_cnt=0, bit_cnt=0.
  - If rx_s=1: treat as a glitch and return to IDLE; no output.
- DATA: each tick increments tick_cnt.
  - On the tick where tick_cnt==15, sample rx_s into the shift register. Shift right, inserting at the MSB, so data is LSB first.
  - On that same tick, set tick_cnt=0 and bit_cnt+1.
  - After the DATA_BITS-th sample, go to STOP.
- STOP: on the tick where tick_cnt==15, sample rx_s, then return to IDLE.
  - rx_s=1: rx_data <= shift, and rx_valid=1.
  - rx_s=0: frame_err=1, and rx_data is unchanged.
- Pulse timing:
  - rx_valid and frame_err are registered. Each is high for exactly the one sys_clk cycle after the stop-sample tick.
  - Each is cleared on the next sys_clk regardless of rx_clk_en.
  - rx_valid and frame_err are never high together.
- Back-to-back frames: IDLE with rx_s=0 on the first tick after STOP starts a new frame immediately. No idle gap is required.
- Break (line held low): each frame sequence ends in frame_err. The receiver then re-enters START on the next tick. Repeated frame_err pulses are legal.
- No overrun buffering: the consumer must capture rx_data within one frame time. A new good frame overwrites rx_data.
- rx_clk_en held low: the FSM freezes in its current state; the synchronizer keeps running.
- Reset mid-frame: the next cycle is at reset values. A partial frame is discarded with no pulse.
- rx_busy is combinational from state.

Test Plan:
1. rx_clk_en every 4 sys_clk; send 0x55 with a good stop bit -> rx_data=0x55 and a 1-cycle rx_valid after the stop-sample tick; frame_err stays 0; rx_busy falls with rx_valid.
2. rxd low for 4 ticks, then high -> START aborts at tick_cnt 7; no rx_valid or frame_err; rx_busy returns to 0.
3. Good frame 0x3C, then frame 0xA3 with the stop bit low -> frame_err pulses once, rx_valid stays 0, rx_data stays 0x3C.
4. Back-to-back 0x00 then 0xFF with no idle bits -> two rx_valid pulses carrying 0x00 then 0xFF.
5. rst asserted for 1 cycle during data bit 3 -> all outputs 0 on the next cycle; a following 0x81 frame is received correctly.
6. rx_clk_en held 0 for 100 cycles while rxd toggles -> state and outputs unchanged; rx_busy stays 0.

Source files
------------

// File: rtl/uart_rx_if.sv
// Receiver-side bundle: oversample tick and serial line in, recovered byte and status pulses out.
// master is the receiver; slave is whatever feeds the line and consumes the bytes.
interface uart_rx_if #(
  parameter int DATA_BITS = 8
);
  logic                 rx_clk_en;
  logic                 rxd;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 frame_err;
  logic                 rx_busy;

  modport master (
    input  rx_clk_en,
    input  rxd,
    output rx_data,
    output rx_valid,
    output frame_err,
    output rx_busy
  );

  modport slave (
    output rx_clk_en,
    output rxd,
    input  rx_data,
    input  rx_valid,
    input  frame_err,
    input  rx_busy
  );
endinterface

// File: rtl/uart_receiver.sv
// UART receive stage: 16x-oversampled start/data/stop recovery with a two-flop line synchronizer.
//
// state | meaning
// IDLE  | line idle, waiting for rx_s low on a tick
// START | counting to mid start bit to confirm it is not a glitch
// DATA  | sampling DATA_BITS data bits, LSB first, one per OVERSAMPLE ticks
// STOP  | sampling the stop bit; high delivers the byte, low flags a framing error
module uart_receiver #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic      sys_clk,
  input  logic      rst,
  uart_rx_if.master bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  localparam int             BW        = $clog2(DATA_BITS);
  localparam logic [3:0]     TICK_MID  = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0]     TICK_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [BW-1:0]  BIT_LAST  = BW'(DATA_BITS - 1);

  logic                 rx_meta;
  logic                 rx_s;
  logic [1:0]           state;
  logic [3:0]           tick_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic [DATA_BITS-1:0] rx_data_q;
  logic                 rx_valid_q;
  logic                 frame_err_q;

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      rx_meta     <= 1'b1;
      rx_s        <= 1'b1;
      state       <= IDLE;
      tick_cnt    <= '0;
      bit_cnt     <= '0;
      shift       <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_meta     <= bus.rxd;
      rx_s        <= rx_meta;
      // status pulses last exactly one sys_clk, independent of the tick rate
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;

      if (bus.rx_clk_en) begin
        case (state)
          IDLE: begin
            if (!rx_s) begin
              state    <= START;
              tick_cnt <= '0;
            end
          end

          START: begin
            if (tick_cnt == TICK_MID) begin
              tick_cnt <= '0;
              bit_cnt  <= '0;
              state    <= rx_s ? IDLE : DATA;
            end else begin
              tick_cnt <= tick_cnt + 4'd1;
            end
          end

          DATA: begin
            if (tick_cnt == TICK_LAST) begin
              shift    <= {rx_s, shift[DATA_BITS-1:1]};
              tick_cnt <= '0;
              bit_cnt  <= bit_cnt + 1'b1;
              if (bit_cnt == BIT_LAST) begin
                state <= STOP;
              end
            end else begin
              tick_cnt <= tick_cnt + 4'd1;
            end
          end

          STOP: begin
            if (tick_cnt == TICK_LAST) begin
              tick_cnt <= '0;
              state    <= IDLE;
              if (rx_s) begin
                rx_data_q  <= shift;
                rx_valid_q <= 1'b1;
              end else begin
                frame_err_q <= 1'b1;
              end
            end else begin
              tick_cnt <= tick_cnt + 4'd1;
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.rx_busy   = (state != IDLE);

  pulse_exclusive: assert property (@(posedge sys_clk) !(rx_valid_q && frame_err_q));

endmodule
